// File: rtl/alu_pkg.sv
// Shared constants for the multi-cycle ALU: opcodes, FSM state encoding and
// the width of the shift-amount counter.
package alu_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_FWD  = 3'b000;
  localparam opcode_t OP_ADD  = 3'b001;
  localparam opcode_t OP_AND  = 3'b010;
  localparam opcode_t OP_OR   = 3'b011;
  localparam opcode_t OP_MULT = 3'b100;
  localparam opcode_t OP_LSL  = 3'b101;
  localparam opcode_t OP_LSR  = 3'b110;
  localparam opcode_t OP_ROR  = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MUL   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  localparam int ALU_WIDTH = 8;

  // Shift count must hold the value WIDTH itself (saturated LSL/LSR), so one
  // bit more than clog2(WIDTH).
  function automatic int shamt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int SHAMT_W = shamt_width(ALU_WIDTH);

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier iterator. One partial product is folded into the
// accumulator per clock; the product is truncated to WIDTH bits.
// Handshake: 'start' is a one-cycle load strobe from the parent FSM;
// 'done' is high (combinationally) during the last iteration cycle, and
// 'product' carries the final accumulator value in that same cycle.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MUL_ITER = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(MUL_ITER - 1);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] partial;

  // Partial product of the current iteration; shifted bits beyond WIDTH drop.
  always_comb begin
    partial = '0;
    if (b_q[cnt_q]) partial = a_q << cnt_q;
  end

  assign done    = run_q && (cnt_q == LAST);
  assign product = acc_q + partial;

  // Next-state for operands, accumulator and iteration counter.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      a_d   = a;
      b_d   = b;
      acc_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = acc_q + partial;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        run_d = 1'b0;
        cnt_d = '0;
      end
    end
  end

  // State registers with synchronous reset (reset aborts any product).
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle FWD/ADD/AND/OR, iterative MULT and
// bit-serial LSL/LSR/ROR. BUSY stalls the PC; RESULT/DONE feed write-back.
// Handshake: START is sampled only in IDLE; the accepting edge captures
// operands and SELECT. DONE is a one-cycle pulse in the cycle RESULT first
// shows the new value. START while BUSY is dropped, never queued.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MUL_ITER = WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  input  logic             START,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       dbg_state
);

  localparam int SHW = shamt_width(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [SHW-1:0]   shcnt_q, shcnt_d;
  logic [2:0]       shop_q, shop_d;

  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [31:0]      d2_ext;
  logic [31:0]      amt_lim;
  logic [31:0]      amt_rot;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] shifted;

  alu_seq_mul #(
    .WIDTH    (WIDTH),
    .MUL_ITER (MUL_ITER)
  ) u_mul (
    .clk     (CLK),
    .rst     (RESET),
    .start   (mul_start),
    .a       (DATA1),
    .b       (DATA2),
    .done    (mul_done),
    .product (mul_product)
  );

  // Shift amount: LSL/LSR saturate at WIDTH, ROR wraps modulo WIDTH.
  always_comb begin
    d2_ext  = 32'(DATA2);
    amt_lim = (d2_ext > 32'(WIDTH)) ? 32'(WIDTH) : d2_ext;
    amt_rot = d2_ext % 32'(WIDTH);
    shamt   = (SELECT == OP_ROR) ? SHW'(amt_rot) : SHW'(amt_lim);
  end

  // One-bit step of the latched shift operation.
  always_comb begin
    shifted = shreg_q;
    case (shop_q)
      OP_LSL:  shifted = {shreg_q[WIDTH-2:0], 1'b0};
      OP_LSR:  shifted = {1'b0, shreg_q[WIDTH-1:1]};
      OP_ROR:  shifted = {shreg_q[0], shreg_q[WIDTH-1:1]};
      default: shifted = shreg_q;
    endcase
  end

  // Control FSM: dispatches ops from IDLE, waits on the multiplier, or
  // steps the shifter until its count runs out.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    done_d    = 1'b0;
    shreg_d   = shreg_q;
    shcnt_d   = shcnt_q;
    shop_d    = shop_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          case (SELECT)
            OP_FWD: begin result_d = DATA2;         done_d = 1'b1; end
            OP_ADD: begin result_d = DATA1 + DATA2; done_d = 1'b1; end
            OP_AND: begin result_d = DATA1 & DATA2; done_d = 1'b1; end
            OP_OR:  begin result_d = DATA1 | DATA2; done_d = 1'b1; end
            OP_MULT: begin
              mul_start = 1'b1;
              state_d   = ST_MUL;
            end
            default: begin
              if (shamt == '0) begin
                result_d = DATA1;
                done_d   = 1'b1;
              end else begin
                shreg_d = DATA1;
                shcnt_d = shamt;
                shop_d  = SELECT;
                state_d = ST_SHIFT;
              end
            end
          endcase
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          result_d = mul_product;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shreg_d = shifted;
        shcnt_d = shcnt_q - 1'b1;
        if (shcnt_q == SHW'(1)) begin
          result_d = shifted;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registers; reset aborts any op in flight and clears RESULT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      shreg_q  <= '0;
      shcnt_q  <= '0;
      shop_q   <= OP_FWD;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      shreg_q  <= shreg_d;
      shcnt_q  <= shcnt_d;
      shop_q   <= shop_d;
    end
  end

  assign RESULT    = result_q;
  assign ZERO      = (result_q == '0);
  assign BUSY      = (state_q != ST_IDLE);
  assign DONE      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops run
// back-to-back, checked by a DONE-driven scoreboard against a plain
// arithmetic reference model.
module tb_alu_seq;

  logic       clk;
  logic       rst;
  logic [7:0] data1;
  logic [7:0] data2;
  logic [2:0] sel;
  logic       start;
  logic [7:0] result;
  logic       zero;
  logic       busy;
  logic       done;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  int         exp_cyc_q[$];

  alu_seq #(.WIDTH(8), .MUL_ITER(8)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .DATA1     (data1),
    .DATA2     (data2),
    .SELECT    (sel),
    .START     (start),
    .RESULT    (result),
    .ZERO      (zero),
    .BUSY      (busy),
    .DONE      (done),
    .dbg_state (dbg_state)
  );

  // Clock and edge counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: result and number of edges after the start edge at
  // which DONE becomes visible.
  function automatic void model(input logic [2:0] op, input logic [7:0] a,
                                input logic [7:0] b, output logic [7:0] r,
                                output int off);
    int ai, bi, n;
    ai = a;
    bi = b;
    off = 0;
    case (op)
      3'd0: r = b;
      3'd1: r = 8'((ai + bi) % 256);
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: begin r = 8'((ai * bi) % 256); off = 8; end
      3'd5: begin
        n = (bi > 8) ? 8 : bi;
        r = (n >= 8) ? 8'd0 : 8'((ai * (1 << n)) % 256);
        off = n;
      end
      3'd6: begin
        n = (bi > 8) ? 8 : bi;
        r = (n >= 8) ? 8'd0 : 8'(ai / (1 << n));
        off = n;
      end
      default: begin
        n = bi % 8;
        r = 8'(((ai / (1 << n)) + (ai * (1 << (8 - n)))) % 256);
        off = n;
      end
    endcase
  endfunction

  // Scoreboard monitor: every DONE pulse consumes one expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: DONE high with no op pending, result=%0h cycle=%0d", result, cyc);
      end else begin
        logic [7:0] er;
        int ec;
        er = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("result", int'(result), int'(er));
        check("zero", int'(zero), int'(er == 8'd0));
        check("done_cycle", cyc, ec);
      end
    end
  end

  // Issue one op at a negedge; return at the negedge of its DONE cycle,
  // checking BUSY along the way. A following call starts back-to-back.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    int off, start_e;
    model(op, a, b, r, off);
    sel = op; data1 = a; data2 = b; start = 1'b1;
    start_e = cyc + 1;
    exp_q.push_back(r);
    exp_cyc_q.push_back(start_e + off);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    data1 = 8'($urandom); data2 = 8'($urandom); sel = 3'($urandom);
    while (cyc < start_e + off) begin
      check("busy_during_op", int'(busy), 1);
      @(negedge clk);
    end
    check("busy_at_done", int'(busy), 0);
  endtask

  initial begin
    logic [2:0] op;
    logic [7:0] a, b;
    int start_e;

    rst = 1'b1; start = 1'b0; data1 = '0; data2 = '0; sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_result", int'(result), 0);
    check("reset_zero", int'(zero), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_state", int'(dbg_state), 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_op(3'd1, 8'd5, 8'd250);
    do_op(3'd1, 8'd1, 8'd255);
    do_op(3'd4, 8'd13, 8'd11);
    do_op(3'd4, 8'd16, 8'd32);
    do_op(3'd5, 8'h81, 8'd3);
    do_op(3'd6, 8'h81, 8'd9);
    do_op(3'd7, 8'h81, 8'd1);
    do_op(3'd5, 8'h5A, 8'd0);
    do_op(3'd7, 8'h81, 8'd9);
    do_op(3'd0, 8'h33, 8'hC4);
    do_op(3'd4, 8'd9, 8'd9);
    do_op(3'd1, 8'd7, 8'd8);
    repeat (2) @(negedge clk);

    // START during MULT is ignored
    sel = 3'd4; data1 = 8'd3; data2 = 8'd4; start = 1'b1;
    start_e = cyc + 1;
    exp_q.push_back(8'd12);
    exp_cyc_q.push_back(start_e + 8);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sel = 3'd1; data1 = 8'd1; data2 = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("ignored_start_busy", int'(busy), 0);

    // Reset in the middle of a MULT
    sel = 3'd4; data1 = 8'd7; data2 = 8'd7; start = 1'b1;
    start_e = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_result", int'(result), 0);
    check("abort_zero", int'(zero), 1);
    check("abort_done", int'(done), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    do_op(3'd1, 8'd2, 8'd2);

    // Random back-to-back ops
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      do_op(op, a, b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (12) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
